// File: rtl/slice_serial_adder.sv
// slice_serial_adder: multi-cycle add/subtract of two WIDTH-bit operands,
// SLICE bits per clock through a registered carry, with valid/ready handshakes
// on both sides and a {carry, sum} result plus signed-overflow flag.
module slice_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_res,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned N     = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets that cannot be processed in whole slices
  if ((WIDTH < 1) || (SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_param_err
    $error("slice_serial_adder: WIDTH must be >= 1 and a multiple of SLICE >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [SLICE:0]       slice_add;
  logic [WIDTH+SLICE-1:0] sum_cat;
  logic [WIDTH-1:0]     sum_shift;
  logic                 top_ovf;
  logic                 last_slice;

  // State, datapath and handshake flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, slice arithmetic and result capture
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;

    slice_add  = {1'b0, opa_q[SLICE-1:0]} + {1'b0, opb_q[SLICE-1:0]} + (SLICE+1)'(carry_q);
    // New slice enters at the top; after N slices the LSB slice sits at bit 0
    sum_cat    = {slice_add[SLICE-1:0], sum_q};
    sum_shift  = WIDTH'(sum_cat >> SLICE);
    // Carry into the MSB is a^b^s at that bit; overflow is that XOR carry-out
    top_ovf    = opa_q[SLICE-1] ^ opb_q[SLICE-1] ^ slice_add[SLICE-1] ^ slice_add[SLICE];
    last_slice = (cnt_q == CNT_W'(N - 1));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          opa_d   = in_a;
          opb_d   = in_sub ? ~in_b : in_b;
          carry_d = in_cin ^ in_sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        opa_d   = opa_q >> SLICE;
        opb_d   = opb_q >> SLICE;
        carry_d = slice_add[SLICE];
        sum_d   = sum_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_slice) begin
          res_d   = {slice_add[SLICE], sum_shift};
          ovf_d   = top_ovf;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_slice_serial_adder.sv
// Bench for slice_serial_adder: directed vector table at WIDTH=8/SLICE=2,
// backpressure and mid-run reset sequences, plus random sweeps at SLICE=1,4,8.
module tb_slice_serial_adder;

  logic clk;
  logic rst;
  logic rst_sw;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Main instance, WIDTH=8 SLICE=2
  logic       in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_ovf, busy;
  logic [7:0] in_a, in_b;
  logic [8:0] out_res;

  slice_serial_adder #(.WIDTH(8), .SLICE(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [8:0] res;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  // Offer operands, wait for the result, then complete the output handshake
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, output logic [8:0] res, output logic ovf,
                        output int lat);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res = out_res;
    ovf = out_ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Random sweep instances at other slice widths, on their own reset
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int unsigned SL = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
    localparam int NL = 8 / SL;
    logic       iv, ir, cin, sub, ov, ordy, ovf, bsy, done;
    logic [7:0] a, b;
    logic [8:0] res;

    slice_serial_adder #(.WIDTH(8), .SLICE(SL)) u_sw (
      .clk       (clk),
      .rst       (rst_sw),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (a),
      .in_b      (b),
      .in_cin    (cin),
      .in_sub    (sub),
      .out_valid (ov),
      .out_ready (ordy),
      .out_res   (res),
      .out_ovf   (ovf),
      .busy      (bsy)
    );

    initial begin
      int ua, ub, sa, sb, r, lat, w;
      logic [8:0] er;
      logic eo;
      iv = 1'b0; cin = 1'b0; sub = 1'b0; ordy = 1'b0; a = '0; b = '0; done = 1'b0;
      @(posedge clk); #1;
      while (rst_sw) begin
        @(posedge clk); #1;
      end
      for (int k = 0; k < 1000; k++) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        if (!sub) begin
          er = 9'(ua + ub + int'(cin));
          r  = sa + sb + int'(cin);
        end else begin
          er[7:0] = 8'(ua - ub - int'(cin));
          er[8]   = (ua >= ub + int'(cin));
          r       = sa - sb - int'(cin);
        end
        eo = (r < -128) || (r > 127);
        w = 0;
        while (ir !== 1'b1 && w < 40) begin
          @(posedge clk); #1; w++;
        end
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        while (ov !== 1'b1 && lat < 40) begin
          @(posedge clk); #1; lat++;
        end
        chk($sformatf("sw%0d_op%0d_res", SL, k), 32'(res), 32'(er));
        chk($sformatf("sw%0d_op%0d_ovf", SL, k), 32'(ovf), 32'(eo));
        chk($sformatf("sw%0d_op%0d_lat", SL, k), 32'(lat), 32'(NL));
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [8:0] res, held;
    logic       ovf;
    int         lat;
    int         c;

    checks = 0; errors = 0;
    rst = 1'b1; rst_sw = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sub: 1'b0, res: 9'h010, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, res: 9'h100, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, res: 9'h080, ovf: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b1, sub: 1'b0, res: 9'h101, ovf: 1'b1};
    vecs[4] = '{a: 8'h05, b: 8'h07, cin: 1'b0, sub: 1'b1, res: 9'h0FE, ovf: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, res: 9'h17F, ovf: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst_sw = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, res, ovf, lat);
      chk($sformatf("vec%0d_res", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_idle_after", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: hold the result in DONE while new operands are offered
    in_a = 8'h22; in_b = 8'h33; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_first_res", 32'(out_res), 32'h055);
    held = out_res;
    for (int k = 0; k < 6; k++) begin
      in_a = 8'(8'hA0 + k); in_b = 8'h0F; in_valid = k[0] ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_res_stable", k), 32'(out_res), 32'(held));
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, res, ovf, lat);
    chk("bp_next_res", 32'(res), 32'h046);
    chk("bp_next_ovf", 32'(ovf), 32'd0);

    // Reset during the second RUN cycle aborts the operation
    in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_res", 32'(out_res), 32'd0);
    c = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) c++;
    end
    chk("abort_no_valid", 32'(c), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, res, ovf, lat);
    chk("abort_next_res", 32'(res), 32'h002);
    chk("abort_next_lat", 32'(lat), 32'd4);

    c = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && c < 60000) begin
      @(posedge clk); c++;
    end
    chk("sweep_done", 32'({g_sw[2].done, g_sw[1].done, g_sw[0].done}), 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
